mdr_mem_port: RTL and testbench

- Memory-side stage that consumes the datapath bus output and produces the MDR bus source.
- Holds the MAR and the MDR.
- Runs a request/acknowledge handshake with a variable-latency word RAM for loads and stores.
- Reports completion (done) and timeout (err) to the control sequencer.

---
 rtl/mdr_mem_port_if.sv | 31 +++
 rtl/mdr_mem_port.sv | 103 ++++++++++
 tb/tb_mdr_mem_port.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mdr_mem_port_if.sv
// RAM-side handshake bundle between the MDR memory port and a word RAM.
// The port drives request, direction, address and write data; the RAM
// answers with acknowledge and read data.
interface mdr_mem_port_if #(
  parameter int ADDR_W = 9
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mdr_mem_port.sv
// Memory-side stage of the datapath: holds MAR and MDR, runs a
// request/acknowledge handshake with a variable-latency word RAM for loads
// and stores, and reports completion (done) and timeout (err).
module mdr_mem_port #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16   // legal range 2..255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxOut,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] BusMuxInMDR,
  output logic        busy,
  output logic        done,
  output logic        err,
  mdr_mem_port_if.master mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Last wait cycle index; reaching it without an ack aborts the access.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  // Only the addressed bits of MAR are ever observable, so only those are kept.
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  // Next-state and register-load decisions; commands and loads only in IDLE.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
        if (MDRin) mdr_d = BusMuxOut;
        // Read has priority; a simultaneous write is dropped.
        if (mem_read) begin
          state_d = S_RD;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else if (mem_write) begin
          state_d = S_WR;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      S_RD, S_WR: begin
        if (mem.mem_ack) begin
          if (state_q == S_RD) mdr_d = mem.mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Counter stays at CNT_LAST; MDR untouched on an aborted read.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign mem.mem_req   = (state_q == S_RD) || (state_q == S_WR);
  assign mem.mem_we    = (state_q == S_WR);
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
  assign busy          = (state_q == S_RD) || (state_q == S_WR);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign BusMuxInMDR   = mdr_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port: reset, loads, zero-wait read, waited
// store, timeout, command collisions and asynchronous clear mid-read.
module tb_mdr_mem_port;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, mem_read, mem_write;
  logic [31:0] BusMuxInMDR;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int req_cycles;
  int done_seen;

  mdr_mem_port_if #(.ADDR_W(9)) mem_bus ();

  mdr_mem_port #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .BusMuxInMDR (BusMuxInMDR),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem         (mem_bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0;
    BusMuxOut = '0;
    MARin = 0; MDRin = 0; mem_read = 0; mem_write = 0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset state
    #12;
    check("rst_req",  32'(mem_bus.mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_mdr",  BusMuxInMDR, 32'h0);
    check("rst_addr", 32'(mem_bus.mem_addr), 32'h0);
    clear = 1'b1;
    tick();

    // Load MAR, zero-wait read
    BusMuxOut = 32'h0000_0025; MARin = 1;
    tick();
    MARin = 0;
    check("rd_addr", 32'(mem_bus.mem_addr), 32'h025);
    mem_read = 1;
    tick();
    mem_read = 0;
    check("rd_req",  32'(mem_bus.mem_req), 32'd1);
    check("rd_we",   32'(mem_bus.mem_we), 32'd0);
    check("rd_busy", 32'(busy), 32'd1);
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_bus.mem_ack = 0;
    check("rd_done", 32'(done), 32'd1);
    check("rd_mdr",  BusMuxInMDR, 32'hDEAD_BEEF);
    check("rd_err",  32'(err), 32'd0);
    check("rd_busy_done", 32'(busy), 32'd0);
    tick();
    check("rd_done_drop", 32'(done), 32'd0);
    check("rd_idle_req",  32'(mem_bus.mem_req), 32'd0);

    // Store with 3 wait states
    BusMuxOut = 32'h1234_5678; MDRin = 1;
    tick();
    MDRin = 0;
    BusMuxOut = 32'h0000_0100; MARin = 1;
    tick();
    MARin = 0;
    mem_write = 1;
    tick();
    mem_write = 0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_req%0d", i),   32'(mem_bus.mem_req), 32'd1);
      check($sformatf("wr_we%0d", i),    32'(mem_bus.mem_we), 32'd1);
      check($sformatf("wr_wdata%0d", i), mem_bus.mem_wdata, 32'h1234_5678);
      check($sformatf("wr_addr%0d", i),  32'(mem_bus.mem_addr), 32'h100);
      if (done) done_seen++;
      if (i == 3) mem_bus.mem_ack = 1;
      tick();
    end
    mem_bus.mem_ack = 0;
    check("wr_done", 32'(done), 32'd1);
    check("wr_err",  32'(err), 32'd0);
    tick();
    if (done) done_seen++;
    check("wr_single_done", 32'(done_seen), 32'd0);
    check("wr_mdr_kept", BusMuxInMDR, 32'h1234_5678);

    // Read timeout, never acked
    mem_read = 1;
    tick();
    mem_read = 0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (mem_bus.mem_req) req_cycles++;
      tick();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_done", 32'(done), 32'd1);
    check("to_err",  32'(err), 32'd1);
    check("to_mdr",  BusMuxInMDR, 32'h1234_5678);
    tick();
    check("to_err_sticky", 32'(err), 32'd1);
    mem_write = 1;
    tick();
    mem_write = 0;
    check("to_err_clear", 32'(err), 32'd0);
    check("to_next_we",   32'(mem_bus.mem_we), 32'd1);
    mem_bus.mem_ack = 1;
    tick();
    mem_bus.mem_ack = 0;
    check("to_next_done", 32'(done), 32'd1);
    tick();

    // Collisions: read beats write; loads/commands ignored while busy
    mem_read = 1; mem_write = 1;
    tick();
    mem_read = 0; mem_write = 0;
    check("col_we",  32'(mem_bus.mem_we), 32'd0);
    check("col_req", 32'(mem_bus.mem_req), 32'd1);
    BusMuxOut = 32'h0000_01FF; MARin = 1; MDRin = 1; mem_write = 1;
    tick();
    MARin = 0; MDRin = 0; mem_write = 0;
    check("col_addr", 32'(mem_bus.mem_addr), 32'h100);
    check("col_mdr",  BusMuxInMDR, 32'h1234_5678);
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_bus.mem_ack = 0;
    check("col_done", 32'(done), 32'd1);
    check("col_mdr_rd", BusMuxInMDR, 32'hCAFE_F00D);
    tick();
    check("col_no_second_req", 32'(mem_bus.mem_req), 32'd0);
    tick();
    check("col_no_second_busy", 32'(busy), 32'd0);

    // Spurious ack in IDLE
    mem_bus.mem_ack = 1;
    tick();
    check("spur_done0", 32'(done), 32'd0);
    tick();
    mem_bus.mem_ack = 0;
    check("spur_done1", 32'(done), 32'd0);
    check("spur_busy",  32'(busy), 32'd0);

    // Asynchronous clear mid-read
    mem_read = 1;
    tick();
    mem_read = 0;
    check("arst_pre_req", 32'(mem_bus.mem_req), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("arst_req",  32'(mem_bus.mem_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(mem_bus.mem_addr), 32'h0);
    check("arst_mdr",  BusMuxInMDR, 32'h0);
    #1 clear = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_idle_done", 32'(done), 32'd0);
    check("arst_idle_err",  32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
